// File: rtl/alu_pipe.sv
// Pipelined ALU with an elastic valid/ready pipeline of STAGES registers.
// Results and flags are computed at accept and carried unchanged through the stages.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SAT_EN = 0
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alua,
  input  logic [WIDTH-1:0] alub,
  input  logic [2:0]       alufunc,
  input  logic             rev_sub,
  input  logic             sat_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluq,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDC = 3'b001,
    OP_SUB  = 3'b010,
    OP_SUBC = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_MOVE = 3'b111
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             c;
    logic             z;
    logic             n;
  } entry_t;

  op_e                op;
  logic               c_q;
  logic [STAGES-1:0]  valid_q;
  entry_t             stg_q [STAGES];
  logic [STAGES-1:0]  free;
  logic [STAGES-1:0]  load_v;
  entry_t             load_d [STAGES];
  entry_t             res;
  logic [WIDTH:0]     wide;
  logic [WIDTH:0]     cin_ext;
  logic               is_add;
  logic               is_sub;
  logic               in_fire;

  assign op = op_e'(alufunc);

  // Handshake: a transfer happens on a cycle where valid and ready are both 1.
  // in_ready may depend combinationally on out_ready; flush and reset block accepts.
  assign in_ready  = resetl && !flush && free[0];
  assign in_fire   = in_valid && in_ready;
  assign out_valid = valid_q[STAGES-1];
  assign aluq      = stg_q[STAGES-1].q;
  assign flag_c    = stg_q[STAGES-1].c;
  assign flag_z    = stg_q[STAGES-1].z;
  assign flag_n    = stg_q[STAGES-1].n;

  // Arithmetic on WIDTH+1 bits; the top bit is carry (add) or borrow (subtract).
  always_comb begin
    cin_ext = '0;
    wide    = '0;
    is_add  = 1'b0;
    is_sub  = 1'b0;
    res     = '0;
    if (op == OP_ADDC || op == OP_SUBC) cin_ext[0] = c_q;
    case (op)
      OP_ADD, OP_ADDC: begin
        is_add = 1'b1;
        wide   = {1'b0, alub} + {1'b0, alua} + cin_ext;
      end
      OP_SUB, OP_SUBC: begin
        is_sub = 1'b1;
        wide   = rev_sub ? ({1'b0, alua} - {1'b0, alub} - cin_ext)
                         : ({1'b0, alub} - {1'b0, alua} - cin_ext);
      end
      OP_AND:  wide = {1'b0, alua & alub};
      OP_OR:   wide = {1'b0, alua | alub};
      OP_XOR:  wide = {1'b0, alua ^ alub};
      default: wide = {1'b0, alua};
    endcase
    res.q = wide[WIDTH-1:0];
    res.c = (op == OP_MOVE) ? c_q : wide[WIDTH];
    if ((SAT_EN != 0) && sat_mode && wide[WIDTH]) begin
      if (is_add) res.q = '1;
      else if (is_sub) res.q = '0;
    end
    res.z = (res.q == '0);
    res.n = res.q[WIDTH-1];
  end

  // A stage can take new data unless it and every stage after it are full with the output stalled.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    free     = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      all_full = all_full & valid_q[s];
      free[s]  = !all_full || out_ready;
    end
  end

  always_comb begin
    load_v[0] = in_fire;
    load_d[0] = res;
    for (int s = 1; s < STAGES; s++) begin
      load_v[s] = valid_q[s-1];
      load_d[s] = stg_q[s-1];
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      c_q     <= 1'b0;
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) stg_q[s] <= '0;
    end else begin
      if (in_fire && op != OP_MOVE) c_q <= res.c;
      for (int s = 0; s < STAGES; s++) begin
        if (flush) begin
          valid_q[s] <= 1'b0;
        end else if (free[s]) begin
          valid_q[s] <= load_v[s];
          if (load_v[s]) stg_q[s] <= load_d[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32, STAGES=2, SAT_EN=1) with a behavioural reference model.
module tb_alu_pipe;
  localparam int W  = 32;
  localparam int ST = 2;

  logic          sys_clk = 1'b0;
  logic          resetl  = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  alua = '0;
  logic [W-1:0]  alub = '0;
  logic [2:0]    alufunc = '0;
  logic          rev_sub = 1'b0;
  logic          sat_mode = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  aluq;
  logic          flag_z, flag_n, flag_c;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  logic [W+2:0] exp_q[$];
  logic [W+2:0] got_q[$];
  int           acc_cyc_q[$];
  int           lat_q[$];
  logic         model_c = 1'b0;

  alu_pipe #(.WIDTH(W), .STAGES(ST), .SAT_EN(1)) dut (
    .sys_clk(sys_clk), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready),
    .alua(alua), .alub(alub), .alufunc(alufunc), .rev_sub(rev_sub), .sat_mode(sat_mode),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .aluq(aluq),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  // Reference: full-precision integer arithmetic, result packed as {q, c, z, n}.
  function automatic logic [W+2:0] ref_op(input logic [2:0] f, input logic [W-1:0] a, b,
                                          input logic rv, sm, cin, output logic cnext);
    longint sa, sb, r;
    logic [W-1:0] q;
    logic c;
    sa = a; sb = b; r = 0; c = 1'b0; q = '0;
    case (f)
      3'd0, 3'd1: begin
        r = sb + sa;
        if (f == 3'd1) r = r + longint'(cin);
        c = (r >= (longint'(1) << W));
        q = r[W-1:0];
      end
      3'd2, 3'd3: begin
        r = rv ? (sa - sb) : (sb - sa);
        if (f == 3'd3) r = r - longint'(cin);
        c = (r < 0);
        q = r[W-1:0];
      end
      3'd4: q = a & b;
      3'd5: q = a | b;
      3'd6: q = a ^ b;
      default: begin q = a; c = cin; end
    endcase
    if (sm && c && f <= 3'd3) q = (f <= 3'd1) ? '1 : '0;
    cnext = c;
    return {q, c, (q == '0), q[W-1]};
  endfunction

  // Scoreboard feed: expected pushed on accept, observed pushed on retire.
  always @(negedge sys_clk) begin
    logic [W+2:0] e;
    logic nc;
    if (!resetl) begin
      model_c = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e = ref_op(alufunc, alua, alub, rev_sub, sat_mode, model_c, nc);
        exp_q.push_back(e);
        model_c = nc;
        acc_cyc_q.push_back(cyc + 1);
      end
      if (out_valid && out_ready) begin
        got_q.push_back({aluq, flag_c, flag_z, flag_n});
        if (acc_cyc_q.size() > 0) lat_q.push_back(cyc - acc_cyc_q.pop_front());
      end
    end
  end

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return '1;
      2: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic send(input logic [2:0] f, input logic [W-1:0] a, b, input logic rv, sm,
                      output bit ok);
    alufunc = f; alua = a; alub = b; rev_sub = rv; sat_mode = sm; in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge sys_clk);
      ok = in_ready;
    end
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(posedge sys_clk); #1;
      if (got_q.size() >= exp_q.size() && !out_valid) break;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); acc_cyc_q.delete(); lat_q.delete();
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({out_valid, aluq, flag_c, flag_z, flag_n, in_ready} !== '0)
      $display("FAIL reset_outputs: got v=%b q=%h c=%b z=%b n=%b rdy=%b, want all 0",
               out_valid, aluq, flag_c, flag_z, flag_n, in_ready);
    else pass_cnt++;
    @(posedge sys_clk); #3;
    resetl = 1'b1;
    @(negedge sys_clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
    else pass_cnt++;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_directed();
    logic [W+2:0] want [4];
    logic [W+2:0] g;
    bit ok, all_ok;
    want[0] = {32'h0000_0000, 1'b1, 1'b1, 1'b0};
    want[1] = {32'h0000_0001, 1'b0, 1'b0, 1'b0};
    want[2] = {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1};
    want[3] = {32'h0000_0002, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    all_ok = 1'b1;
    send(3'b000, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, ok); all_ok &= ok;
    send(3'b001, 32'h0, 32'h0, 1'b0, 1'b0, ok);         all_ok &= ok;
    send(3'b010, 32'h5, 32'h3, 1'b0, 1'b0, ok);         all_ok &= ok;
    send(3'b010, 32'h5, 32'h3, 1'b1, 1'b0, ok);         all_ok &= ok;
    drain();
    total_cnt++;
    if (!all_ok || got_q.size() != 4)
      $display("FAIL directed_count: got %0d results accept_ok=%0d, want 4 accept_ok=1", got_q.size(), all_ok);
    else pass_cnt++;
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      total_cnt++;
      if (g !== want[i]) $display("FAIL directed_%0d: got %h want %h", i, g, want[i]);
      else pass_cnt++;
    end
    clear_sb();
  endtask

  task automatic test_sat();
    logic [W+2:0] want [3];
    logic [W+2:0] g;
    bit ok, all_ok;
    want[0] = {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};
    want[1] = {32'h0000_0000, 1'b1, 1'b1, 1'b0};
    want[2] = {32'h0000_0005, 1'b0, 1'b0, 1'b0};
    all_ok = 1'b1;
    send(3'b000, 32'h20, 32'hFFFF_FFF0, 1'b0, 1'b1, ok); all_ok &= ok;
    send(3'b010, 32'h7, 32'h2, 1'b0, 1'b1, ok);          all_ok &= ok;
    send(3'b010, 32'h2, 32'h7, 1'b0, 1'b1, ok);          all_ok &= ok;
    drain();
    total_cnt++;
    if (!all_ok || got_q.size() != 3)
      $display("FAIL sat_count: got %0d results accept_ok=%0d, want 3 accept_ok=1", got_q.size(), all_ok);
    else pass_cnt++;
    for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      total_cnt++;
      if (g !== want[i]) $display("FAIL sat_%0d: got %h want %h", i, g, want[i]);
      else pass_cnt++;
    end
    clear_sb();
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] g, e;
    int n, lat;
    bit ok, all_ok;
    clear_sb();
    out_ready = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ok);
      all_ok &= ok;
    end
    drain();
    n = exp_q.size();
    total_cnt++;
    if (!all_ok || n != 20 || got_q.size() != 20)
      $display("FAIL b2b_count: got exp=%0d obs=%0d ok=%0d, want 20/20/1", n, got_q.size(), all_ok);
    else pass_cnt++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL b2b_result: got %h want %h", g, e);
      else pass_cnt++;
    end
    while (lat_q.size() > 0) begin
      lat = lat_q.pop_front();
      total_cnt++;
      if (lat != ST - 1) $display("FAIL b2b_latency: got %0d edges want %0d", lat, ST - 1);
      else pass_cnt++;
    end
    clear_sb();
  endtask

  task automatic test_stream();
    logic [2:0]   fs [8];
    logic [W-1:0] as [8], bs [8];
    logic [W+2:0] prev, g, e;
    logic prev_stall, exp_rdy;
    int acc, inflight;
    clear_sb();
    for (int i = 0; i < 8; i++) begin
      fs[i] = 3'($urandom_range(0, 7)); as[i] = rand_opnd(); bs[i] = rand_opnd();
    end
    acc = 0; inflight = 0; prev_stall = 1'b0; prev = '0;
    for (int c = 0; c < 200 && (acc < 8 || got_q.size() < 8); c++) begin
      out_ready = (c % 3 == 0);
      in_valid  = (acc < 8);
      alufunc = fs[acc % 8]; alua = as[acc % 8]; alub = bs[acc % 8];
      rev_sub = 1'b0; sat_mode = 1'b0;
      @(negedge sys_clk);
      exp_rdy = !(inflight == ST && !out_ready);
      total_cnt++;
      if (in_ready !== exp_rdy)
        $display("FAIL stream_in_ready: got %b want %b (inflight %0d)", in_ready, exp_rdy, inflight);
      else pass_cnt++;
      if (prev_stall) begin
        total_cnt++;
        if ({aluq, flag_c, flag_z, flag_n} !== prev || out_valid !== 1'b1)
          $display("FAIL stream_stall_hold: got v=%b %h want v=1 %h", out_valid,
                   {aluq, flag_c, flag_z, flag_n}, prev);
        else pass_cnt++;
      end
      if (in_valid && in_ready) begin acc++; inflight++; end
      if (out_valid && out_ready) inflight--;
      prev_stall = out_valid && !out_ready;
      prev = {aluq, flag_c, flag_z, flag_n};
      @(posedge sys_clk); #1;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (got_q.size() != 8 || exp_q.size() != 8)
      $display("FAIL stream_count: got obs=%0d exp=%0d want 8/8", got_q.size(), exp_q.size());
    else pass_cnt++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL stream_result: got %h want %h", g, e);
      else pass_cnt++;
    end
    clear_sb();
  endtask

  task automatic test_random_stall();
    logic [W+2:0] g, e;
    clear_sb();
    for (int c = 0; c < 60; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      alufunc = 3'($urandom_range(0, 7)); alua = rand_opnd(); alub = rand_opnd();
      rev_sub = 1'($urandom_range(0, 1)); sat_mode = 1'($urandom_range(0, 1));
      @(posedge sys_clk); #1;
    end
    drain();
    total_cnt++;
    if (got_q.size() != exp_q.size() || exp_q.size() == 0)
      $display("FAIL random_count: got obs=%0d want %0d (nonzero)", got_q.size(), exp_q.size());
    else pass_cnt++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL random_result: got %h want %h", g, e);
      else pass_cnt++;
    end
    clear_sb();
  endtask

  task automatic test_flush();
    logic [W+2:0] g;
    bit ok, all_ok;
    clear_sb();
    out_ready = 1'b0;
    all_ok = 1'b1;
    send(3'b000, 32'h1, 32'h1, 1'b0, 1'b0, ok);                 all_ok &= ok;
    send(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, ok); all_ok &= ok;
    flush = 1'b1; in_valid = 1'b1;
    alufunc = 3'b100; alua = rand_opnd(); alub = rand_opnd();
    @(negedge sys_clk);
    total_cnt++;
    if (in_ready !== 1'b0 || !all_ok)
      $display("FAIL flush_in_ready: got rdy=%b ok=%0d want rdy=0 ok=1", in_ready, all_ok);
    else pass_cnt++;
    @(posedge sys_clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge sys_clk);
    total_cnt++;
    if (out_valid !== 1'b0 || got_q.size() != 0)
      $display("FAIL flush_clear: got v=%b retired=%0d want v=0 retired=0", out_valid, got_q.size());
    else pass_cnt++;
    @(posedge sys_clk); #1;
    clear_sb();
    out_ready = 1'b1;
    send(3'b001, 32'h0, 32'h0, 1'b0, 1'b0, ok);
    drain();
    total_cnt++;
    if (got_q.size() != 1 || !ok)
      $display("FAIL flush_addc_count: got %0d ok=%0d want 1 ok=1", got_q.size(), ok);
    else begin
      g = got_q.pop_front();
      if (g !== {32'h1, 1'b0, 1'b0, 1'b0})
        $display("FAIL flush_addc: got %h want %h", g, {32'h1, 1'b0, 1'b0, 1'b0});
      else pass_cnt++;
    end
    clear_sb();
  endtask

  task automatic test_async_reset();
    logic [W+2:0] g;
    bit ok, all_ok;
    clear_sb();
    out_ready = 1'b0;
    all_ok = 1'b1;
    send(3'b000, 32'h2, 32'hFFFF_FFFF, 1'b0, 1'b0, ok); all_ok &= ok;
    send(3'b101, 32'hF0, 32'h0F, 1'b0, 1'b0, ok);       all_ok &= ok;
    @(negedge sys_clk);
    total_cnt++;
    if (out_valid !== 1'b1 || !all_ok)
      $display("FAIL areset_pre: got v=%b ok=%0d want v=1 ok=1", out_valid, all_ok);
    else pass_cnt++;
    @(posedge sys_clk); #2;
    resetl = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, aluq, flag_c, flag_z, flag_n, in_ready} !== '0)
      $display("FAIL areset_async: got v=%b q=%h c=%b z=%b n=%b rdy=%b want all 0",
               out_valid, aluq, flag_c, flag_z, flag_n, in_ready);
    else pass_cnt++;
    @(posedge sys_clk); #3;
    resetl = 1'b1;
    clear_sb();
    out_ready = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    total_cnt++;
    if (got_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL areset_stale: got retired=%0d v=%b want 0/0", got_q.size(), out_valid);
    else pass_cnt++;
    send(3'b001, 32'h0, 32'h0, 1'b0, 1'b0, ok);
    drain();
    total_cnt++;
    if (got_q.size() != 1 || !ok)
      $display("FAIL areset_addc_count: got %0d ok=%0d want 1 ok=1", got_q.size(), ok);
    else begin
      g = got_q.pop_front();
      if (g !== {32'h0, 1'b0, 1'b1, 1'b0})
        $display("FAIL areset_addc: got %h want %h", g, {32'h0, 1'b0, 1'b1, 1'b0});
      else pass_cnt++;
    end
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sat();
    test_back_to_back();
    test_stream();
    test_random_stall();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
